// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arbiter
// Description : N-to-1 multiplexer with a registered, round-robin arbitrated
//               select. Each input channel offers a word with a valid/ready
//               handshake. The winning word is captured into a single output
//               register and presented with its channel index.
//               Optional feature macro: SEL_OVERRIDE_EN adds force_en and
//               force_sel for a manual channel select.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arbiter #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*WIDTH-1:0]     in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CHANNELS)-1:0]   out_sel
`ifdef SEL_OVERRIDE_EN
    ,
    input  logic                          force_en,
    input  logic [$clog2(CHANNELS)-1:0]   force_sel
`endif
);

    localparam int SELW = $clog2(CHANNELS);
    // Channel count widened by one bit so pointer+offset sums compare cleanly.
    localparam logic [SELW:0] c_NUM_CH = (SELW+1)'(CHANNELS);

    logic [WIDTH-1:0]    r_out_data;
    logic                r_out_valid;
    logic [SELW-1:0]     r_out_sel;
    logic [SELW-1:0]     r_ptr;

    logic                w_slot_free;
    logic                w_rr_found;
    logic [SELW-1:0]     w_rr_win;
    logic [SELW:0]       w_sum;
    logic                w_grant;
    logic [SELW-1:0]     w_win;
    logic                w_upd_ptr;
    logic [CHANNELS-1:0] w_grant_vec;
    logic [WIDTH-1:0]    w_sel_data;

    // Output register can take a new word when empty or being drained now.
    assign w_slot_free = !r_out_valid || out_ready;

    // Round-robin search: first valid channel after the last winner, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_win   = '0;
        w_sum      = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            w_sum = {1'b0, r_ptr} + (SELW+1)'(k);
            if (w_sum >= c_NUM_CH) begin
                w_sum = w_sum - c_NUM_CH;
            end
            if (!w_rr_found && in_valid[w_sum[SELW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_win   = w_sum[SELW-1:0];
            end
        end
    end

    // Final grant decision; a manual select bypasses and freezes the pointer.
    always_comb begin
        w_win     = w_rr_win;
        w_upd_ptr = 1'b1;
        w_grant   = w_slot_free && w_rr_found;
`ifdef SEL_OVERRIDE_EN
        if (force_en) begin
            w_win     = force_sel;
            w_upd_ptr = 1'b0;
            w_grant   = w_slot_free && ({1'b0, force_sel} < c_NUM_CH)
                        && in_valid[force_sel];
        end
`endif
    end

    // One-hot ready on the winner and the winner's data word; ready is held
    // low during reset so no producer believes its word was taken.
    always_comb begin
        w_grant_vec = '0;
        w_sel_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_win == SELW'(i)) begin
                w_grant_vec[i] = w_grant && rst_n;
                w_sel_data     = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = w_grant_vec;

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_sel   <= '0;
            r_ptr       <= SELW'(CHANNELS - 1);
        end else if (w_slot_free) begin
            if (w_grant) begin
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_win;
                r_out_valid <= 1'b1;
                if (w_upd_ptr) begin
                    r_ptr <= w_win;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_mux_arbiter
// Description : Scoreboard bench for rr_mux_arbiter (CHANNELS=4, WIDTH=8).
//               Directed vectors push expected words into a queue; a monitor
//               pops and compares whenever the DUT hands a word downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_mux_arbiter;

    localparam int CH = 4;
    localparam int W  = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH*W-1:0] in_data;
    logic [CH-1:0]   in_valid;
    logic [CH-1:0]   in_ready;
    logic [W-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      out_sel;
`ifdef SEL_OVERRIDE_EN
    logic            force_en;
    logic [1:0]      force_sel;
`endif

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [9:0]  exp_q[$];
    logic [9:0]  mon_exp;
    logic [7:0]  ch_data [CH];

    always #5 clk = ~clk;

    rr_mux_arbiter #(.CHANNELS(CH), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sel   (out_sel)
`ifdef SEL_OVERRIDE_EN
        ,
        .force_en  (force_en),
        .force_sel (force_sel)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Drive one cycle of requests, check the grant, queue the expected word.
    task automatic drive(input logic [3:0] v, input logic rdy, input logic [3:0] exp_rdy,
                         input string name);
        in_valid  = v;
        out_ready = rdy;
        #1;
        check(name, {28'b0, in_ready}, {28'b0, exp_rdy});
        for (int i = 0; i < CH; i++) begin
            if (exp_rdy[i]) exp_q.push_back({2'(i), ch_data[i]});
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every downstream transfer must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got sel=%0d data=%0h, required no transfer",
                         out_sel, out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_sel", {30'b0, out_sel}, {30'b0, mon_exp[9:8]});
                check("out_data", {24'b0, out_data}, {24'b0, mon_exp[7:0]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        ch_data[0] = 8'hA5;
        ch_data[1] = 8'h3C;
        ch_data[2] = 8'h5A;
        ch_data[3] = 8'hC3;
        for (int i = 0; i < CH; i++) in_data[i*W +: W] = ch_data[i];
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
`ifdef SEL_OVERRIDE_EN
        force_en  = 1'b0;
        force_sel = 2'd0;
`endif

        // Reset state, with all channels requesting
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_data", {24'b0, out_data}, 32'd0);
        check("reset_out_sel", {30'b0, out_sel}, 32'd0);
        check("reset_in_ready", {28'b0, in_ready}, 32'd0);
        rst_n = 1'b1;

        // Single word from ch0
        drive(4'b0001, 1'b1, 4'b0001, "t2_grant_ch0");
        drive(4'b0000, 1'b1, 4'b0000, "t2_idle");

        // Re-reset so the pointer starts at CHANNELS-1 again
        rst_n    = 1'b0;
        in_valid = 4'b1111;
        #1;
        check("rereset_in_ready", {28'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rereset_out_valid", {31'b0, out_valid}, 32'd0);
        rst_n = 1'b1;

        // Full-throughput rotation 0,1,2,3,0
        drive(4'b1111, 1'b1, 4'b0001, "t3_g0");
        drive(4'b1111, 1'b1, 4'b0010, "t3_g1");
        drive(4'b1111, 1'b1, 4'b0100, "t3_g2");
        drive(4'b1111, 1'b1, 4'b1000, "t3_g3");
        drive(4'b1111, 1'b1, 4'b0001, "t3_g0_again");

        // Stall for 3 cycles, output must stay put
        for (int s = 0; s < 3; s++) begin
            check("t4_stall_valid", {31'b0, out_valid}, 32'd1);
            check("t4_stall_data", {24'b0, out_data}, {24'b0, ch_data[0]});
            check("t4_stall_sel", {30'b0, out_sel}, 32'd0);
            drive(4'b0110, 1'b0, 4'b0000, "t4_stall_in_ready");
        end
        drive(4'b0110, 1'b1, 4'b0010, "t4_release_ch1");

        // Lone ch3 request, then again after the wrap search
        drive(4'b1000, 1'b1, 4'b1000, "t5_ch3");
        drive(4'b1000, 1'b1, 4'b1000, "t5_wrap_ch3");
        drive(4'b0000, 1'b1, 4'b0000, "t5_idle");
        check("t5_idle_valid", {31'b0, out_valid}, 32'd0);
        check("t5_hold_data", {24'b0, out_data}, {24'b0, ch_data[3]});
        check("t5_hold_sel", {30'b0, out_sel}, 32'd3);

`ifdef SEL_OVERRIDE_EN
        // Manual select: ch2 only, pointer stays at 3
        force_en  = 1'b1;
        force_sel = 2'd2;
        drive(4'b0101, 1'b1, 4'b0100, "t6_force_ch2");
        force_en  = 1'b0;
        drive(4'b1111, 1'b1, 4'b0001, "t6_ptr_kept");
        force_en  = 1'b1;
        force_sel = 2'd3;
        drive(4'b0111, 1'b1, 4'b0000, "t6_force_invalid");
        check("t6_out_valid_fall", {31'b0, out_valid}, 32'd0);
        force_en  = 1'b0;
`endif

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
